// File: rtl/bus_pkg.sv
// Shared system-bus definitions: arbiter state encoding, master limits and
// data_mask_bus byte-lane encodings used by the arbiter and slave decoders.
package bus_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int WDOG_W      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  // data_mask_bus byte-lane enables, bit n selects byte lane n
  localparam int         DMASK_W       = 4;
  localparam logic [3:0] DMASK_NONE    = 4'b0000;
  localparam logic [3:0] DMASK_BYTE0   = 4'b0001;
  localparam logic [3:0] DMASK_BYTE1   = 4'b0010;
  localparam logic [3:0] DMASK_BYTE2   = 4'b0100;
  localparam logic [3:0] DMASK_BYTE3   = 4'b1000;
  localparam logic [3:0] DMASK_HALF_LO = 4'b0011;
  localparam logic [3:0] DMASK_HALF_HI = 4'b1100;
  localparam logic [3:0] DMASK_WORD    = 4'b1111;

  function automatic int unsigned wrap_inc(input int unsigned cur, input int unsigned n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set bit of i_eligible at or
// after i_start (ascending, wrapping). Zero latency, no flow control.
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_eligible,
  input  logic [IW-1:0] i_start,
  output logic          o_valid,
  output logic [IW-1:0] o_index
);

  // Walk offsets from farthest to nearest so the nearest eligible index wins.
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_eligible[(int'(i_start) + k) % N]) begin
        o_valid = 1'b1;
        o_index = IW'((int'(i_start) + k) % N);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus_req/bus_grant arbiter with a one-cycle turnaround between owners and an
// fc_bus watchdog; grant one cycle after request in IDLE, owner holds the bus until it drops req.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MASTERS-1:0]         bus_req,
  output logic [N_MASTERS-1:0]         bus_grant,
  input  logic                         rd_bus,
  input  logic                         wr_bus,
  input  logic                         fc_bus,
  output logic                         bus_busy,
  output logic [$clog2(N_MASTERS)-1:0] grant_id,
  output logic                         bus_timeout,
  output logic [$clog2(N_MASTERS)-1:0] timeout_id
);

  localparam int                IW     = $clog2(N_MASTERS);
  localparam logic [WDOG_W-1:0] TO_CNT = WDOG_W'(TIMEOUT);

  arb_state_t           r_state, w_state_nxt;
  logic [N_MASTERS-1:0] r_grant, w_grant_nxt;
  logic                 r_busy, w_busy_nxt;
  logic [IW-1:0]        r_grant_id, w_grant_id_nxt;
  logic [IW-1:0]        r_last_owner, w_last_owner_nxt;
  logic                 r_tout, w_tout_nxt;
  logic [IW-1:0]        r_tout_id, w_tout_id_nxt;
  logic [N_MASTERS-1:0] r_mask, w_mask_set;
  logic [WDOG_W-1:0]    r_cnt, w_cnt_step, w_cnt_nxt;

  logic [N_MASTERS-1:0] w_elig;
  logic [IW-1:0]        w_start;
  logic                 w_pick_vld;
  logic [IW-1:0]        w_pick_idx;
  logic                 w_strobe;

  assign w_strobe = rd_bus | wr_bus;
  assign w_elig   = bus_req & ~r_mask;
  assign w_start  = IW'(wrap_inc(32'(r_last_owner), N_MASTERS));

  rr_pick #(.N(N_MASTERS)) u_pick (
    .i_eligible (w_elig),
    .i_start    (w_start),
    .o_valid    (w_pick_vld),
    .o_index    (w_pick_idx)
  );

  // Watchdog only advances while a strobe is outstanding without completion.
  always_comb begin
    w_cnt_step = '0;
    if (fc_bus || !w_strobe) begin
      w_cnt_step = '0;
    end else if (&r_cnt) begin
      w_cnt_step = r_cnt;
    end else begin
      w_cnt_step = r_cnt + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_busy_nxt       = r_busy;
    w_grant_id_nxt   = r_grant_id;
    w_last_owner_nxt = r_last_owner;
    w_tout_nxt       = 1'b0;
    w_tout_id_nxt    = r_tout_id;
    w_mask_set       = '0;
    w_cnt_nxt        = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt              = OWNED;
          w_grant_nxt              = '0;
          w_grant_nxt[w_pick_idx]  = 1'b1;
          w_busy_nxt               = 1'b1;
          w_grant_id_nxt           = w_pick_idx;
          w_last_owner_nxt         = w_pick_idx;
        end
      end
      OWNED: begin
        w_cnt_nxt = w_cnt_step;
        // A revoke takes precedence over a simultaneous voluntary release.
        if (w_cnt_step == TO_CNT) begin
          w_state_nxt              = TURN;
          w_grant_nxt              = '0;
          w_busy_nxt               = 1'b0;
          w_tout_nxt               = 1'b1;
          w_tout_id_nxt            = r_grant_id;
          w_mask_set[r_grant_id]   = 1'b1;
          w_cnt_nxt                = '0;
        end else if (!bus_req[r_grant_id]) begin
          w_state_nxt = TURN;
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      TURN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant      <= '0;
      r_busy       <= 1'b0;
      r_grant_id   <= '0;
      r_last_owner <= IW'(N_MASTERS - 1);
      r_tout       <= 1'b0;
      r_tout_id    <= '0;
      r_mask       <= '0;
      r_cnt        <= '0;
    end else begin
      r_grant      <= w_grant_nxt;
      r_busy       <= w_busy_nxt;
      r_grant_id   <= w_grant_id_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_tout       <= w_tout_nxt;
      r_tout_id    <= w_tout_id_nxt;
      r_mask       <= w_mask_set | (r_mask & bus_req);
      r_cnt        <= w_cnt_nxt;
    end
  end

  assign bus_grant   = r_grant;
  assign bus_busy    = r_busy;
  assign grant_id    = r_grant_id;
  assign bus_timeout = r_tout;
  assign timeout_id  = r_tout_id;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural arbitration model.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] bus_req = '0;
  logic         rd_bus = 1'b0, wr_bus = 1'b0, fc_bus = 1'b0;
  logic [N-1:0] bus_grant;
  logic         bus_busy, bus_timeout;
  logic [1:0]   grant_id, timeout_id;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.N_MASTERS(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_grant(bus_grant),
    .rd_bus(rd_bus), .wr_bus(wr_bus), .fc_bus(fc_bus), .bus_busy(bus_busy),
    .grant_id(grant_id), .bus_timeout(bus_timeout), .timeout_id(timeout_id)
  );

  typedef struct {
    logic [N-1:0] req;
    logic         rd;
    logic [N-1:0] grant;
    logic         busy;
    logic [1:0]   gid;
  } vec_t;

  vec_t tbl[16];

  // Behavioural model: owner index (-1 = bus free), turnaround flag, blocked set.
  int m_owner, m_last, m_wait, m_gid, m_tid;
  bit m_turn, m_tout;
  bit m_blk[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus_req = '0; rd_bus = 1'b0; wr_bus = 1'b0; fc_bus = 1'b0;
    #2 rst = 1'b0;
    #4 rst = 1'b1;
    step();
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_wait = 0; m_gid = 0; m_tid = 0;
    m_turn = 1'b0; m_tout = 1'b0;
    for (int i = 0; i < N; i++) m_blk[i] = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic strobe, input logic fc);
    int revoke;
    int c;
    revoke = -1;
    m_tout = 1'b0;
    if (m_owner >= 0) begin
      if (fc || !strobe) m_wait = 0;
      else if (m_wait < 65535) m_wait++;
      if (m_wait == TO) begin
        m_tout = 1'b1; m_tid = m_owner; revoke = m_owner;
        m_owner = -1; m_turn = 1'b1; m_wait = 0;
      end else if (!req[m_owner]) begin
        m_owner = -1; m_turn = 1'b1; m_wait = 0;
      end
    end else if (m_turn) begin
      m_turn = 1'b0;
    end else begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (req[c] && !m_blk[c]) begin
          m_owner = c; m_last = c; m_gid = c;
          break;
        end
      end
    end
    for (int i = 0; i < N; i++) if (!req[i]) m_blk[i] = 1'b0;
    if (revoke >= 0) m_blk[revoke] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    int gap;
    int exp_i;
    logic [N-1:0] exp_grant;

    // Reset state while rst is held low
    #7;
    chk("rst_grant", bus_grant, 0);
    chk("rst_busy", bus_busy, 0);
    chk("rst_tout", bus_timeout, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_tid", timeout_id, 0);
    rst = 1'b1;
    step();

    // Directed vectors: single request, release, turnaround, no preemption
    tbl[0]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0};
    tbl[1]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0};
    tbl[2]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[3]  = '{4'b0010, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[4]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[5]  = '{4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[6]  = '{4'b0100, 1'b1, 4'b0000, 1'b0, 2'd1};
    tbl[7]  = '{4'b0100, 1'b0, 4'b0000, 1'b0, 2'd1};
    tbl[8]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};
    tbl[9]  = '{4'b0101, 1'b0, 4'b0100, 1'b1, 2'd2};
    tbl[10] = '{4'b0101, 1'b0, 4'b0100, 1'b1, 2'd2};
    tbl[11] = '{4'b0001, 1'b0, 4'b0000, 1'b0, 2'd2};
    tbl[12] = '{4'b0001, 1'b0, 4'b0000, 1'b0, 2'd2};
    tbl[13] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0};
    tbl[14] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[15] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
    for (int v = 0; v < 16; v++) begin
      bus_req = tbl[v].req;
      rd_bus  = tbl[v].rd;
      step();
      chk($sformatf("vec%0d_grant", v), bus_grant, tbl[v].grant);
      chk($sformatf("vec%0d_busy", v), bus_busy, tbl[v].busy);
      chk($sformatf("vec%0d_gid", v), grant_id, tbl[v].gid);
      chk($sformatf("vec%0d_tout", v), bus_timeout, 0);
    end

    // Round-robin with all masters requesting
    do_reset();
    bus_req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_i = n % N;
      gap = 0;
      while (bus_grant == 0 && gap < 20) begin
        gap++;
        step();
      end
      chk($sformatf("rr%0d_grant", n), bus_grant, 32'(1 << exp_i));
      chk($sformatf("rr%0d_gid", n), grant_id, exp_i);
      if (n > 0) chk($sformatf("rr%0d_gap_ge2", n), 32'(gap >= 2), 1);
      step();
      step();
      bus_req[exp_i] = 1'b0;
      step();
      chk($sformatf("rr%0d_release", n), bus_grant, 0);
      bus_req[exp_i] = 1'b1;
    end
    bus_req = '0;
    step();
    step();

    // Watchdog revoke
    do_reset();
    bus_req = 4'b0010;
    step();
    chk("to_grant", bus_grant, 4'b0010);
    rd_bus = 1'b1;
    for (int i = 1; i <= TO; i++) begin
      step();
      if (i < TO) begin
        chk($sformatf("to_wait%0d_tout", i), bus_timeout, 0);
        chk($sformatf("to_wait%0d_grant", i), bus_grant, 4'b0010);
      end
    end
    chk("to_pulse", bus_timeout, 1);
    chk("to_grant_cleared", bus_grant, 0);
    chk("to_busy", bus_busy, 0);
    chk("to_tid", timeout_id, 1);
    step();
    chk("to_pulse_width", bus_timeout, 0);
    rd_bus = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("to_masked%0d", i), bus_grant, 0);
    end
    bus_req = '0;
    step();
    bus_req = 4'b0010;
    step();
    chk("to_regrant", bus_grant, 4'b0010);
    chk("to_regrant_gid", grant_id, 1);

    // Completion on the cycle the count would reach TIMEOUT
    rd_bus = 1'b1;
    repeat (TO - 1) step();
    fc_bus = 1'b1;
    step();
    chk("fc_beats_tout", bus_timeout, 0);
    chk("fc_grant_kept", bus_grant, 4'b0010);
    fc_bus = 1'b0;
    repeat (TO - 1) step();
    chk("fc_restart_no_early", bus_timeout, 0);
    step();
    chk("fc_restart_tout", bus_timeout, 1);
    rd_bus = 1'b0;
    bus_req = '0;
    step();
    step();

    // Asynchronous reset mid-tenure
    bus_req = 4'b0001;
    step();
    chk("arst_pre_grant", bus_grant, 4'b0001);
    #3 rst = 1'b0;
    #1;
    chk("arst_grant", bus_grant, 0);
    chk("arst_busy", bus_busy, 0);
    chk("arst_tid", timeout_id, 0);
    #2 rst = 1'b1;
    bus_req = 4'b1000;
    step();
    chk("arst_after_grant", bus_grant, 4'b1000);
    chk("arst_after_gid", grant_id, 3);

    // Randomized traffic against the model
    do_reset();
    model_reset();
    for (int t = 0; t < 800; t++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 11) == 0) bus_req[b] = ~bus_req[b];
      end
      rd_bus = ($urandom_range(0, 7) != 0);
      wr_bus = ($urandom_range(0, 15) == 0);
      fc_bus = ($urandom_range(0, 9) == 0);
      model_step(bus_req, rd_bus | wr_bus, fc_bus);
      step();
      exp_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      chk($sformatf("rand%0d_grant", t), bus_grant, exp_grant);
      chk($sformatf("rand%0d_busy", t), bus_busy, 32'(m_owner >= 0));
      chk($sformatf("rand%0d_gid", t), grant_id, m_gid);
      chk($sformatf("rand%0d_tout", t), bus_timeout, m_tout);
      chk($sformatf("rand%0d_tid", t), timeout_id, m_tid);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Arbiter for the shared system bus (`addr_bus`/`data_bus`/`rd_bus`/`wr_bus`/`data_mask_bus`/`fc_bus`). It shares the bus between up to `N_MASTERS` requesters (cpu, DMA, debug port) using the existing `bus_req`/`bus_grant` handshake, with round-robin fairness. It inserts one dead cycle between owners for tristate turnaround. A watchdog revokes the bus from any master whose transfer gets no `fc_bus` within `TIMEOUT` cycles.

## Interface
- `N_MASTERS`, 4: number of requesters, 2..8.
- `TIMEOUT`, 255: max cycles a transfer may wait for `fc_bus`, 1..65535.
- `clk`  in  1: system clock, all state on rising edge.
- `rst`  in  1: asynchronous, active-low reset (0 = reset).
- `bus_req`  in  N_MASTERS: per-master request, level, held for whole tenure.
- `bus_grant`  out  N_MASTERS: per-master grant, one-hot or zero, registered.
- `rd_bus`, `wr_bus`  in  1 each: monitored bus strobes.
- `fc_bus`  in  1: monitored function-complete from slave.
- `bus_busy`  out  1: some grant bit is high.
- `grant_id`  out  $clog2(N_MASTERS): index of current or last owner.
- `bus_timeout`  out  1: one-cycle pulse on watchdog revoke.
- `timeout_id`  out  $clog2(N_MASTERS): owner at last timeout, sticky.

## Operation
- States: IDLE, OWNED, TURN.
- IDLE: if any eligible `bus_req`, pick winner, go OWNED, set its `bus_grant` bit. Otherwise stay.
- Eligible: `bus_req[i]` = 1 and `mask[i]` = 0.
- Round-robin search starts at `(last_owner+1) mod N_MASTERS`, ascending with wrap. The first eligible index wins.
- `last_owner` updates on every grant. Reset value is N_MASTERS-1, so index 0 wins first.
- OWNED: grant held while owner's `bus_req` = 1. Other requests are ignored, with no preemption.
- OWNED, owner drops `bus_req`: clear grant, go TURN.
- TURN: all grants 0 for exactly one cycle, then IDLE. Arbitration happens in IDLE, so the minimum gap between owners is 2 grant-free cycles.
- Watchdog counter, 16 bits:
  - Cleared in IDLE/TURN.
  - Cleared in OWNED when `fc_bus` = 1 or `rd_bus|wr_bus` = 0.
  - Otherwise increments, saturating.
- When counter == TIMEOUT in OWNED:
  - `bus_timeout` pulses.
  - `timeout_id` = owner.
  - `mask[owner]` set.
  - Grant cleared, go TURN.
- `mask[i]` clears on any cycle where `bus_req[i]` = 0. A revoked master must drop and re-raise its request before it can win again.
- Owner's `bus_req` drop and timeout in the same cycle: timeout wins. Pulse, mask set, and mask clears next cycle since req is low.
- `fc_bus` in the same cycle counter reaches TIMEOUT: no timeout, counter clears.

## Timing
- Request-to-grant latency:
  - `bus_req` sampled high at edge k in IDLE gives `bus_grant` high after edge k+1 (visible from cycle k+1).
  - From TURN, latency is 2 cycles.
- Release: owner `bus_req` low at edge k gives grant low after edge k, then TURN cycle, then IDLE.
- Timeout: strobe asserted with no `fc_bus` from cycle s leads to the pulse at cycle s+TIMEOUT and grant low the same cycle.
- `bus_timeout` is high for exactly one cycle.
- Reset values:
  - `bus_grant` = 0, `bus_busy` = 0, `bus_timeout` = 0.
  - `grant_id` = 0, `timeout_id` = 0.
  - State IDLE, mask = 0, counter = 0.
- Reset mid-tenure drops the grant asynchronously. It never glitches high.
- All outputs come from registers.

## Structure
- `bus_pkg`:
  - state enum `arb_state_t` {IDLE, OWNED, TURN}.
  - `MAX_MASTERS` = 8.
  - shared bus mask encodings for later slave decoders.
- Sub-module `rr_pick`: combinational round-robin priority encoder. Inputs are the eligible vector and start index. Outputs are `valid` and `index`. It is reused later by the interrupt controller.
- Top: state register, owner/last_owner, mask, watchdog counter.

## Test plan
- Single request: reset, `bus_req`=4'b0001 → `bus_grant`=4'b0001 one cycle later, `grant_id`=0. Drop req → grant 0, one TURN cycle, `bus_busy`=0.
- Round-robin: `bus_req`=4'b1111 held; each owner drops and re-raises after 3 cycles → grant order 0,1,2,3,0, each separated by ≥2 grant-free cycles.
- No preemption: master 2 owns; master 0 raises req → grant stays 4'b0100 until master 2 drops.
- Timeout: TIMEOUT=8, master 1 owns, `rd_bus`=1, `fc_bus`=0 → `bus_timeout` pulse 8 cycles after strobe, `timeout_id`=1, grant cleared. Master 1 keeps req high → never re-granted. Drop/raise → granted.
- Completion beats timeout: `fc_bus`=1 on the exact TIMEOUT cycle → no pulse, grant kept.
- Async reset: `rst`=0 mid-tenure, between edges → `bus_grant`=0 immediately. After release, req 4'b1000 → grant 4'b1000.
